// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding, halt-cause codes and IMEM addressing helper
// for the pipeline boot/fault controller.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SETTLE, ST_RUN, ST_HALT} state_t;

    localparam logic [1:0] HALT_NONE       = 2'd0;
    localparam logic [1:0] HALT_DERR       = 2'd1;
    localparam logic [1:0] HALT_HWFAULT    = 2'd2;
    localparam logic [1:0] HALT_SERR_LIMIT = 2'd3;

    localparam int IMEM_ADDR_SHIFT = 2;

    function automatic logic [31:0] word_to_byte(input logic [15:0] idx);
        return {16'd0, idx} << IMEM_ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/pipeline_boot_ctrl_ecc_err_monitor.sv
// ecc_err_monitor: saturating single-bit ECC error counter and halt-cause priority encoder.
// fault/cause are combinational; the parent registers them on the transition to HALT.
module ecc_err_monitor
    import pipeline_ctrl_pkg::*;
#(
    parameter int SERR_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       s_err_imem,
    input  logic       d_err_imem,
    input  logic       s_err_dmem,
    input  logic       d_err_dmem,
    input  logic       hw_fault,
    output logic [7:0] count,
    output logic       fault,
    output logic [1:0] cause
);

    logic       derr;
    logic       serr;
    logic       hit;
    logic [8:0] next_count;

    always_comb begin
        derr       = d_err_imem | d_err_dmem;
        serr       = s_err_imem | s_err_dmem;
        next_count = {1'b0, count} + 9'd1;
        hit        = serr && next_count >= 9'(SERR_LIMIT);
        cause      = derr ? HALT_DERR : hw_fault ? HALT_HWFAULT : hit ? HALT_SERR_LIMIT : HALT_NONE;
        fault      = en && cause != HALT_NONE;
    end

    // A cycle already halting for a higher-priority cause does not count its single error
    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en && serr && !derr && !hw_fault && count != 8'hff)
            count <= next_count[7:0];
    end

endmodule

// File: rtl/pipeline_boot_ctrl.sv
// pipeline_boot_ctrl: loads IMEM from a valid/ready word stream, holds the core in reset
// through a settle interval, then runs it and halts it on unrecoverable ECC/ALU faults.
module pipeline_boot_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int IMEM_DEPTH    = 256,
    parameter int SETTLE_CYCLES = 4,
    parameter int SERR_LIMIT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [15:0] load_len,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    output logic        src_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        loader_done,
    output logic        core_rst_n,
    input  logic        s_err_imem,
    input  logic        d_err_imem,
    input  logic        s_err_dmem,
    input  logic        d_err_dmem,
    input  logic        hardware_fault_flag,
    input  logic        clear_fault,
    output logic        busy,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [7:0]  serr_count
);

    localparam logic [15:0] DEPTH_W = 16'(IMEM_DEPTH);

    state_t      state;
    state_t      nxt;
    logic [15:0] len;
    logic [15:0] idx;
    logic [15:0] settle_cnt;
    logic        start_ok;
    logic        handshake;
    logic        fault;
    logic [1:0]  cause;

    always_comb begin
        start_ok  = load_start && load_len != '0;
        handshake = state == ST_LOAD && src_valid;
        nxt       = state;
        case (state)
            ST_IDLE:   nxt = start_ok ? ST_LOAD : ST_IDLE;
            ST_LOAD:   nxt = handshake && idx == len - 16'd1 ? ST_SETTLE : ST_LOAD;
            ST_SETTLE: nxt = settle_cnt == 16'(SETTLE_CYCLES - 1) ? ST_RUN : ST_SETTLE;
            ST_RUN:    nxt = fault ? ST_HALT : ST_RUN;
            ST_HALT:   nxt = start_ok ? ST_LOAD : clear_fault ? ST_SETTLE : ST_HALT;
            default:   nxt = ST_IDLE;
        endcase
    end

    ecc_err_monitor #(.SERR_LIMIT(SERR_LIMIT)) u_mon (
        .clk        (clk),
        .rst        (rst),
        .en         (state == ST_RUN),
        .clr        (state == ST_HALT && nxt != ST_HALT),
        .s_err_imem (s_err_imem),
        .d_err_imem (d_err_imem),
        .s_err_dmem (s_err_dmem),
        .d_err_dmem (d_err_dmem),
        .hw_fault   (hardware_fault_flag),
        .count      (serr_count),
        .fault      (fault),
        .cause      (cause)
    );

    // Status outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            len         <= '0;
            idx         <= '0;
            settle_cnt  <= '0;
            src_ready   <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            core_rst_n  <= 1'b0;
            loader_done <= 1'b0;
            imem_we     <= 1'b0;
            imem_waddr  <= '0;
            imem_wdata  <= '0;
            halt_cause  <= HALT_NONE;
        end else begin
            state       <= nxt;
            src_ready   <= nxt == ST_LOAD;
            busy        <= nxt == ST_LOAD;
            halted      <= nxt == ST_HALT;
            core_rst_n  <= nxt == ST_RUN;
            loader_done <= nxt == ST_SETTLE || nxt == ST_RUN || nxt == ST_HALT;
            imem_we     <= handshake;
            settle_cnt  <= state == ST_SETTLE ? settle_cnt + 16'd1 : '0;
            if (handshake) begin
                imem_waddr <= word_to_byte(idx);
                imem_wdata <= src_data;
                idx        <= idx + 16'd1;
            end
            if (nxt == ST_LOAD && state != ST_LOAD) begin
                len <= load_len > DEPTH_W ? DEPTH_W : load_len;
                idx <= '0;
            end
            if (state == ST_RUN && fault)
                halt_cause <= cause;
            else if (state == ST_HALT && nxt != ST_HALT)
                halt_cause <= HALT_NONE;
        end
    end

endmodule

// File: tb/tb_pipeline_boot_ctrl.sv
// tb_pipeline_boot_ctrl: randomized scoreboard bench; stimulus pushes expected IMEM writes
// and halt causes, a negedge monitor pops and compares them as the DUT presents them.
module tb_pipeline_boot_ctrl;

    localparam int DEPTH  = 256;
    localparam int SETTLE = 4;
    localparam int LIMIT  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [15:0] load_len = '0;
    logic        src_valid = 1'b0;
    logic [31:0] src_data = '0;
    logic        src_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        loader_done;
    logic        core_rst_n;
    logic        s_err_imem = 1'b0;
    logic        d_err_imem = 1'b0;
    logic        s_err_dmem = 1'b0;
    logic        d_err_dmem = 1'b0;
    logic        hardware_fault_flag = 1'b0;
    logic        clear_fault = 1'b0;
    logic        busy;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [7:0]  serr_count;

    int          checks = 0;
    int          failures = 0;
    int          writes = 0;
    logic [63:0] wq[$];
    logic [1:0]  hq[$];
    logic [63:0] exp_w;
    logic [1:0]  exp_c;
    logic        prev_halted = 1'b0;
    logic [31:0] prog[3] = '{32'h00500093, 32'h00300113, 32'h002081B3};

    always #5 clk = ~clk;

    pipeline_boot_ctrl #(.IMEM_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .SERR_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .loader_done(loader_done), .core_rst_n(core_rst_n),
        .s_err_imem(s_err_imem), .d_err_imem(d_err_imem),
        .s_err_dmem(s_err_dmem), .d_err_dmem(d_err_dmem),
        .hardware_fault_flag(hardware_fault_flag), .clear_fault(clear_fault),
        .busy(busy), .halted(halted), .halt_cause(halt_cause), .serr_count(serr_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe and every halt entry must match a pushed expectation
    always @(negedge clk) begin
        if (imem_we) begin
            writes++;
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", imem_waddr, imem_wdata);
            end else begin
                exp_w = wq.pop_front();
                chk("write_addr", imem_waddr, exp_w[63:32]);
                chk("write_data", imem_wdata, exp_w[31:0]);
            end
        end
        if (halted && !prev_halted) begin
            if (hq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_halt: cause %0d with no halt expected", halt_cause);
            end else begin
                exp_c = hq.pop_front();
                chk("halt_cause_mon", 32'(halt_cause), 32'(exp_c));
            end
        end
        prev_halted = halted;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int n, input logic with_clear);
        load_start  = 1'b1;
        load_len    = 16'(n);
        clear_fault = with_clear;
        tick();
        load_start  = 1'b0;
        clear_fault = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("halted_after_start", halted, 0);
        chk("cause_cleared_on_load", halt_cause, 0);
        chk("count_cleared_on_load", serr_count, 0);
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid
    task automatic do_load(input int n_req, input int mode, input logic fixed);
        int   n;
        int   i;
        int   cyc;
        logic v;
        n = n_req > DEPTH ? DEPTH : n_req;
        i = 0;
        cyc = 0;
        while (i < n) begin
            v = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(1, 0));
            chk("ready_in_load", src_ready, 1);
            src_valid  = v;
            src_data   = fixed ? prog[i % 3] : $urandom;
            load_start = $urandom_range(3, 0) == 0;
            load_len   = 16'($urandom);
            if (v) begin
                wq.push_back({(32'(i) << 2), src_data});
                i++;
            end
            tick();
            chk("we_follows_handshake", imem_we, v);
            cyc++;
        end
        src_valid  = 1'b0;
        load_start = 1'b0;
        chk("ready_after_last", src_ready, 0);
        chk("loader_done_with_last_write", loader_done, 1);
        chk("core_held_after_load", core_rst_n, 0);
        chk("busy_after_load", busy, 0);
    endtask

    // Error flags and source words are driven randomly here; all must be ignored
    task automatic settle_phase(input int w0, input int n);
        for (int k = 1; k <= SETTLE; k++) begin
            s_err_imem = 1'($urandom_range(1, 0));
            s_err_dmem = 1'($urandom_range(1, 0));
            d_err_imem = 1'($urandom_range(1, 0));
            d_err_dmem = 1'($urandom_range(1, 0));
            hardware_fault_flag = 1'($urandom_range(1, 0));
            src_valid = 1'($urandom_range(1, 0));
            src_data  = $urandom;
            tick();
            chk("core_rst_n_settle", core_rst_n, k == SETTLE);
            chk("loader_done_settle", loader_done, 1);
            chk("serr_ignored_settle", serr_count, 0);
            chk("no_halt_settle", halted, 0);
        end
        {s_err_imem, s_err_dmem, d_err_imem, d_err_dmem, hardware_fault_flag, src_valid} = '0;
        chk("write_count", 32'(writes - w0), 32'(n));
    endtask

    task automatic run_random();
        int       cnt;
        int       guard;
        logic     done;
        logic [1:0] ec;
        cnt = 0;
        guard = 0;
        done = 1'b0;
        ec = 2'd0;
        while (!done && guard < 400) begin
            d_err_imem = $urandom_range(39, 0) == 0;
            d_err_dmem = $urandom_range(39, 0) == 0;
            hardware_fault_flag = $urandom_range(39, 0) == 0;
            s_err_imem = $urandom_range(3, 0) == 0;
            s_err_dmem = $urandom_range(3, 0) == 0;
            load_start = $urandom_range(7, 0) == 0;
            load_len   = 16'd5;
            clear_fault = $urandom_range(7, 0) == 0;
            if (d_err_imem || d_err_dmem) begin
                done = 1'b1;
                ec = 2'd1;
            end else if (hardware_fault_flag) begin
                done = 1'b1;
                ec = 2'd2;
            end else if (s_err_imem || s_err_dmem) begin
                cnt++;
                if (cnt >= LIMIT) begin
                    done = 1'b1;
                    ec = 2'd3;
                end
            end
            if (done) hq.push_back(ec);
            tick();
            chk("serr_count_run", serr_count, 32'(cnt));
            chk("halted_run", halted, done);
            chk("core_rst_n_run", core_rst_n, !done);
            chk("busy_run", busy, 0);
            guard++;
        end
        {s_err_imem, s_err_dmem, d_err_imem, d_err_dmem, hardware_fault_flag, load_start, clear_fault} = '0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL run_random_timeout: no halt predicted within %0d cycles", guard);
        end else begin
            chk("halt_cause_run", halt_cause, ec);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        repeat (3) tick();
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_loader_done", loader_done, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_waddr", imem_waddr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_halt_cause", halt_cause, 0);
        chk("rst_serr_count", serr_count, 0);
        rst = 1'b0;
        tick();

        // zero-length load is ignored
        load_start = 1'b1;
        load_len   = 16'd0;
        tick();
        load_start = 1'b0;
        chk("zero_len_busy", busy, 0);
        chk("zero_len_ready", src_ready, 0);

        // three-word program, valid held high
        w0 = writes;
        start_load(3, 1'b0);
        do_load(3, 0, 1'b1);
        settle_phase(w0, 3);

        // sixteen single errors force a limit halt
        for (int p = 1; p <= LIMIT; p++) begin
            s_err_dmem = 1'b1;
            s_err_imem = p == 5;
            if (p == LIMIT) hq.push_back(2'd3);
            tick();
            {s_err_dmem, s_err_imem} = '0;
            chk("serr_pulse_count", serr_count, 32'(p));
            chk("serr_pulse_halt", halted, p == LIMIT);
            if (p < LIMIT) repeat ($urandom_range(2, 0)) begin
                tick();
                chk("serr_gap_count", serr_count, 32'(p));
            end
        end
        chk("serr_limit_cause", halt_cause, 3);
        chk("serr_limit_core_rst", core_rst_n, 0);
        chk("serr_limit_loader_done", loader_done, 1);

        // clear_fault restarts without reloading
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("clear_halted", halted, 0);
        chk("clear_count", serr_count, 0);
        chk("clear_cause", halt_cause, 0);
        chk("clear_busy", busy, 0);
        settle_phase(writes, 0);

        // double error outranks hardware fault
        d_err_imem = 1'b1;
        hardware_fault_flag = 1'b1;
        hq.push_back(2'd1);
        tick();
        {d_err_imem, hardware_fault_flag} = '0;
        chk("derr_priority_halted", halted, 1);
        chk("derr_priority_cause", halt_cause, 1);

        repeat (4) begin
            clear_fault = 1'b1;
            tick();
            clear_fault = 1'b0;
            settle_phase(writes, 0);
            run_random();
        end

        // clear_fault and load_start together: load wins, toggling valid
        w0 = writes;
        start_load(4, 1'b1);
        do_load(4, 1, 1'b0);
        settle_phase(w0, 4);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_from_run_core", core_rst_n, 0);
        chk("rst_from_run_done", loader_done, 0);

        // over-long load is clamped to IMEM depth
        w0 = writes;
        start_load(300, 1'b0);
        do_load(300, 2, 1'b0);
        settle_phase(w0, DEPTH);

        // reset in the middle of a load, then restart from address 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_load(5, 1'b0);
        for (int i = 0; i < 2; i++) begin
            src_valid = 1'b1;
            src_data  = $urandom;
            wq.push_back({(32'(i) << 2), src_data});
            tick();
        end
        src_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midload_rst_ready", src_ready, 0);
        chk("midload_rst_done", loader_done, 0);
        chk("midload_rst_core", core_rst_n, 0);
        chk("midload_rst_busy", busy, 0);
        w0 = writes;
        start_load(3, 1'b0);
        do_load(3, 0, 1'b1);
        settle_phase(w0, 3);

        // load_start during RUN is ignored
        load_start = 1'b1;
        load_len   = 16'd7;
        tick();
        load_start = 1'b0;
        chk("run_ignores_start_busy", busy, 0);
        chk("run_ignores_start_core", core_rst_n, 1);

        tick();
        tick();
        chk("writes_drained", 32'(wq.size()), 0);
        chk("halts_drained", 32'(hq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_boot_ctrl.md
# pipeline_boot_ctrl

Boot and fault controller for the five-stage pipeline core. Accepts a stream of instruction words over a valid/ready port and writes them into instruction memory through the core's IMEM write interface. Holds the core in reset until the load finishes and a settle interval has elapsed, then releases it. In run mode it watches the core's ECC and spare-ALU fault outputs and halts the core (re-asserts core reset) on an unrecoverable fault.

## Interface
Parameters:
- `IMEM_DEPTH`, 256: IMEM capacity in 32-bit words; `load_len` is clamped to this value.
- `SETTLE_CYCLES`, 4: cycles the core is held in reset after the last word is written (≥1).
- `SERR_LIMIT`, 16: count of single-bit ECC errors in run mode that forces a halt (1–255).

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `load_start`  in  1  one-cycle pulse: begin a load (honoured only in IDLE or HALT)
- `load_len`  in  16  number of words to load; sampled on `load_start`
- `src_valid`  in  1  instruction-word source valid
- `src_data`  in  32  instruction word
- `src_ready`  out  1  controller accepts the word
- `imem_we`  out  1  IMEM write strobe (to core)
- `imem_waddr`  out  32  IMEM byte address (to core)
- `imem_wdata`  out  32  IMEM write data (to core)
- `loader_done`  out  1  IMEM contents valid (to core)
- `core_rst_n`  out  1  active-low core reset (to core `rst`)
- `s_err_imem`, `d_err_imem`, `s_err_dmem`, `d_err_dmem`  in  1 each  ECC flags from core
- `hardware_fault_flag`  in  1  spare-ALU fault flag from core
- `clear_fault`  in  1  restart the core from HALT without reloading
- `busy`  out  1  state is LOAD
- `halted`  out  1  state is HALT
- `halt_cause`  out  2  0 none, 1 double ECC, 2 hardware fault, 3 single-error limit
- `serr_count`  out  8  count of single-bit errors in RUN; saturating

## Operation
- States: IDLE, LOAD, SETTLE, RUN, HALT.
- Reset: state IDLE. Reset values of all outputs:
  - `core_rst_n`=0, `loader_done`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0
  - `src_ready`=0, `busy`=0, `halted`=0, `halt_cause`=0, `serr_count`=0
- IDLE: `load_start` with `load_len`≠0 → LOAD. Latch `len = min(load_len, IMEM_DEPTH)`, clear the word index. `load_start` with `load_len`=0 is ignored.
- LOAD:
  - `src_ready`=1 throughout. Each `src_valid&src_ready` handshake writes IMEM at `imem_waddr = idx*4`, `imem_wdata = src_data`, then increments `idx`.
  - The handshake of word `len-1` → SETTLE. `load_start` is ignored in LOAD.
- SETTLE:
  - `loader_done`=1 and `core_rst_n`=0 for exactly `SETTLE_CYCLES` cycles, then → RUN.
  - Error inputs are ignored.
- RUN: `core_rst_n`=1, `loader_done`=1. Monitoring, evaluated every cycle:
  - `d_err_imem|d_err_dmem` → HALT, cause 1.
  - Otherwise `hardware_fault_flag` → HALT, cause 2.
  - Otherwise each cycle with `s_err_imem|s_err_dmem` increments `serr_count` by 1. Both flags high in the same cycle counts once. The count saturates at 255.
  - `serr_count` reaching `SERR_LIMIT` → HALT, cause 3.
  - `load_start` and `clear_fault` are ignored.
- HALT:
  - `core_rst_n`=0, `loader_done` stays 1, `halt_cause` holds.
  - `load_start` (with `load_len`≠0) → LOAD and clears cause and count.
  - `clear_fault` → SETTLE and clears cause and count.
  - If both are asserted, `load_start` wins.
- Reset mid-load: return to IDLE immediately. `loader_done`=0. Partially written IMEM is invalid.

## Timing
- All outputs are registered.
- IMEM write latency: a handshake in cycle t produces `imem_we`=1 with its address and data in cycle t+1. Back-to-back handshakes give back-to-back write strobes.
- `src_ready` is a decode of the registered state. The last handshake in cycle t gives state SETTLE and `src_ready`=0 in cycle t+1.
- `loader_done` rises in the same cycle as the final `imem_we`.
- `core_rst_n` rises `SETTLE_CYCLES` cycles after SETTLE entry.
- Fault seen in cycle t in RUN: `halted`=1, `core_rst_n`=0 and `halt_cause` valid in cycle t+1.
- The increment that reaches `SERR_LIMIT` in cycle t gives HALT in cycle t+1, with `serr_count`=`SERR_LIMIT`.
- `load_start` in cycle t from IDLE or HALT gives `busy`=1 in cycle t+1.

## Structure
- Package `pipeline_ctrl_pkg`:
  - state encoding
  - `halt_cause` codes (`HALT_NONE`, `HALT_DERR`, `HALT_HWFAULT`, `HALT_SERR_LIMIT`)
  - IMEM word-to-byte shift constant
- One sub-module, `ecc_err_monitor`: the saturating single-error counter plus cause priority encode.
  - Inputs: enable, clear, the five flags.
  - Outputs: count, `fault`, `cause`.
- The FSM, load counter and settle counter live in `pipeline_boot_ctrl`.

## Test plan
- Load of 3 words (`0x00500093`, `0x00300113`, `0x002081B3`), `src_valid` held high → writes at addresses 0, 4, 8 on consecutive cycles. `loader_done` rises with the third write; `core_rst_n` rises 4 cycles later.
- `src_valid` toggling every other cycle during a load of `load_len`=4 → exactly 4 writes, addresses 0–12, no write in idle cycles. `load_len`=300 with `IMEM_DEPTH`=256 → exactly 256 writes, last address 1020.
- RUN, `s_err_dmem` pulsed 16 times → `serr_count`=16, halt with cause 3 one cycle after the 16th pulse. `d_err_imem` and `hardware_fault_flag` asserted together → cause 1.
- In HALT, `clear_fault` → SETTLE, `serr_count`=0, core released after 4 cycles with no IMEM writes. `clear_fault` and `load_start` together → LOAD.
- `rst` asserted after 2 of 5 words → next cycle IDLE, `loader_done`=0, `src_ready`=0, `core_rst_n`=0. A following `load_start` restarts from address 0.
